// File: rtl/wide_add_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : wide_add_sequencer_pkg
// Brief  : Shared constants, state encoding and counter sizing helper.
// Rev    : 1.0 - initial release
// ============================================================================
package wide_add_sequencer_pkg;

    localparam int CHUNK_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Never returns less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wide_add_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module : wide_add_sequencer_if
// Brief  : Operand (valid/ready) and result (valid/ready) bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface wide_add_sequencer_if #(
    parameter int WIDTH = 128
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/wide_add_sequencer_bentkung.sv
`default_nettype none
// ============================================================================
// Module : bentkung
// Brief  : 32-bit Brent-Kung parallel-prefix adder used as the chunk adder.
// Rev    : 1.0 - initial release
// ============================================================================
module bentkung (
    input  wire logic [31:0] a,
    input  wire logic [31:0] b,
    input  wire logic        cin,
    output logic      [31:0] s,
    output logic             cout
);
    logic [31:0] w_g;
    logic [31:0] w_p;
    logic [31:0] w_gg;
    logic [31:0] w_pp;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Carry-in folded into bit 0's generate; w_gg[i] ends as carry out of bit i.
    always_comb begin
        w_gg    = w_g;
        w_pp    = w_p;
        w_gg[0] = w_g[0] | (w_p[0] & cin);
        for (int lvl = 0; lvl < 5; lvl++) begin
            for (int i = (2 << lvl) - 1; i < 32; i += (2 << lvl)) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << lvl)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << lvl)];
            end
        end
        for (int lvl = 3; lvl >= 0; lvl--) begin
            for (int i = (3 << lvl) - 1; i < 32; i += (2 << lvl)) begin
                w_gg[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << lvl)]);
                w_pp[i] = w_pp[i] & w_pp[i - (1 << lvl)];
            end
        end
    end

    assign s    = w_p ^ {w_gg[30:0], cin};
    assign cout = w_gg[31];
endmodule
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module : wide_add_sequencer
// Brief  : WIDTH-bit adder built by sequencing 32-bit chunks through bentkung.
// Rev    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  wire logic             clk,
    input  wire logic             rst,
    wide_add_sequencer_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK_W;
    localparam int CNT_W  = clog2(NCHUNK);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    generate
        if (((WIDTH % CHUNK_W) != 0) || (WIDTH < 64)) begin : g_width_check
            $error("wide_add_sequencer: WIDTH must be a multiple of 32 and >= 64");
        end
    endgenerate

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_accept;
    logic               w_last;
    logic [CHUNK_W-1:0] w_s;
    logic               w_cout;

    bentkung u_chunk_add (
        .a    (r_a[CHUNK_W-1:0]),
        .b    (r_b[CHUNK_W-1:0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_last   = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept)      w_state_nxt = RUN;
            RUN:  if (w_last)        w_state_nxt = DONE;
            DONE: if (bus.out_ready) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // in_ready is also gated by rst so the source never sees a ready during reset.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE:    w_in_ready  = ~rst;
            DONE:    w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_accept) begin
                r_a     <= bus.in_a;
                r_b     <= bus.in_b;
                r_carry <= bus.in_cin;
                r_cnt   <= '0;
            end else if (r_state == RUN) begin
                r_sum   <= {w_s, r_sum[WIDTH-1:CHUNK_W]};
                r_a     <= {{CHUNK_W{1'b0}}, r_a[WIDTH-1:CHUNK_W]};
                r_b     <= {{CHUNK_W{1'b0}}, r_b[WIDTH-1:CHUNK_W]};
                r_carry <= w_cout;
                if (w_last) begin
                    r_cout <= w_cout;
                    // Operand sign bits sit at bit 31 of the shift regs in the final chunk.
                    r_ovf  <= (r_a[CHUNK_W-1] == r_b[CHUNK_W-1]) &&
                              (w_s[CHUNK_W-1] != r_a[CHUNK_W-1]);
                end else begin
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_sum   = r_sum;
    assign bus.out_cout  = r_cout;
    assign bus.out_ovf   = r_ovf;
endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder that feeds the existing 32-bit Brent-Kung adder (bentkung) one 32-bit chunk per cycle.
- Chains the carry through a register and reassembles a WIDTH-bit sum.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Gives datapath clients 64/128/256-bit addition while reusing the single verified 32-bit adder.

Parameters:
- WIDTH, 128, operand/sum width in bits; must be a multiple of 32 and >= 64 (checked at elaboration).
- NCHUNK, WIDTH/32, derived chunk count; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept operands
- in_a  input  WIDTH  operand A, unsigned/two's-complement
- in_b  input  WIDTH  operand B
- in_cin  input  1  carry-in to bit 0
- out_valid  output  1  result valid
- out_ready  input  1  sink accepts result
- out_sum  output  WIDTH  A+B+cin, modulo 2^WIDTH
- out_cout  output  1  unsigned carry out of bit WIDTH-1
- out_ovf  output  1  signed overflow flag

Behaviour:
- Clock/reset: one clock clk; reset rst is asynchronous and active-high.
- Reset values while rst=1:
  - state=IDLE, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, chunk counter=0, carry reg=0.
  - in_ready forced 0 while rst=1; in_ready=1 in IDLE once rst=0.
- IDLE (in_ready=1, out_valid=0):
  - On in_valid&&in_ready at edge T: latch in_a, in_b into shift regs, carry reg<=in_cin, counter<=0, state<=RUN.
  - Inputs are sampled only at this edge.
- RUN (in_ready=0, out_valid=0):
  - bentkung inputs each cycle: a=a_sh[31:0], b=b_sh[31:0], cin=carry reg.
  - Each edge:
    - result reg shifts right 32 with s entering [WIDTH-1:WIDTH-32].
    - a_sh/b_sh shift right 32.
    - carry reg<=cout; counter++.
  - On the edge where counter==NCHUNK-1:
    - out_cout<=cout.
    - out_ovf<=(a_sh[31]==b_sh[31])&&(s[31]!=a_sh[31]), taken from the final chunk.
    - state<=DONE.
- DONE (out_valid=1, in_ready=0):
  - out_sum/out_cout/out_ovf held stable until out_valid&&out_ready.
  - On that handshake edge: state<=IDLE, out_valid<=0.
  - out_sum keeps its last value after out_valid drops (don't-care to sink).
- Latency: out_valid rises at edge T+NCHUNK (4 cycles after accept for WIDTH=128).
- Throughput:
  - One operation per NCHUNK+2 cycles with out_ready held high.
  - No overlap: in_ready=0 in RUN and DONE.
- Boundary conditions:
  - in_valid outside IDLE: ignored, no buffering.
  - in_valid with X data in IDLE: sampled as given; no protection.
  - rst asserted mid-RUN or mid-DONE: operation aborted, result discarded, no out_valid pulse; after release block is in IDLE.
  - Counter wrap: counter never exceeds NCHUNK-1; reset to 0 on accept.
  - out_ready high while out_valid=0: no effect.
  - Full carry propagation (all-ones + cin=1): carry ripples through every chunk register; sum=0, cout=1.
- Arithmetic: {out_cout,out_sum} == in_a+in_b+in_cin exactly (WIDTH+1 bits). out_ovf is the two's-complement overflow of in_a+in_b+in_cin.

Decomposition:
- Shared package/include holds:
  - CHUNK_W=32.
  - State encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter width function clog2(NCHUNK).
- Sub-module: the existing bentkung adder, instantiated once as the chunk adder (ports a,b,cin,s,cout). It is not reimplemented or modified.
- FSM, shift registers and output registers are in wide_add_sequencer itself.

Test Plan:
- Carry through all chunks: a=all-ones(128), b=0, cin=1 -> out_sum=0, out_cout=1, out_ovf=0; out_valid exactly 4 cycles after accept edge.
- Chunk-boundary carry: a=0x...0000_FFFFFFFF, b=1, cin=0 -> out_sum=0x...0001_00000000, out_cout=0, out_ovf=0.
- Signed overflow: a=0x7FFF...FFFF, b=1, cin=0 -> out_sum=0x8000...0000, out_ovf=1, out_cout=0; a=0x8000...0, b=0x8000...0 -> sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands -> out_valid stays 1, out_sum stable, in_ready=0, new operands not taken; out_ready=1 -> IDLE next edge, then new operands accepted.
- Reset mid-operation: assert rst asynchronously during RUN chunk 2 -> out_valid=0, out_sum=0 immediately; after release in_ready=1 and next op (a=5, b=7, cin=1) yields 13.
- Random regression: 10000 random {a,b,cin} back-to-back with out_ready=1 -> every result matches a+b+cin (129-bit reference); one result every 6 cycles; repeat with WIDTH=64 and WIDTH=256.
